spi_flash_responder: RTL
========================

# spi_flash_responder

SPI flash device emulator. It acts as the slave end of the flash link that our SPI flash master drives. It oversamples `spi_clk`, `spi_cs` and `spi_di` in the system clock domain, decodes Read Status (0x05) and Read Data (0x03), and serves read bytes from a synchronous byte-memory port. It is used as a bench/board stand-in for the physical flash, and as a flash-compatible target for an external host.

## Interface
- `JEDEC_ID`, default 24'hEF4016: 3-byte ID returned by 0x9F (only with `SPI_FLASH_RESP_JEDEC_EN`).
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `spi_clk` input, 1 bit: SPI clock from master. Asynchronous; mode 0.
- `spi_cs` input, 1 bit: chip select, active-low. Asynchronous.
- `spi_di` input, 1 bit: master-to-responder data (MOSI).
- `spi_do` output, 1 bit: responder-to-master data (MISO).
- `status_in` input, 8 bits: status register value returned by 0x05.
- `mem_addr` output, 24 bits: byte address of the fetch.
- `mem_rd` output, 1 bit: one-cycle fetch strobe.
- `mem_data` input, 8 bits: fetched byte. Valid exactly 1 `clk` after `mem_rd`.
- `cmd_out` output, 8 bits: last decoded opcode.
- `cmd_valid` output, 1 bit: one-cycle pulse when an opcode completes.
- `busy` output, 1 bit: high while a frame is in progress (CS low and armed).

## Operation
- Synchronisation: `spi_clk`, `spi_cs` and `spi_di` each pass through a 2-FF synchroniser. Edge detection runs on the synchronised `spi_clk`: rise = sample, fall = shift out.
- Frame start is the synchronised `spi_cs` falling. Frame end is `spi_cs` rising, which returns the block to IDLE from any state, sets `spi_do` to 1 and clears the bit counters.
- States:
  - IDLE: `spi_do`=1. On CS low, go to CMD.
  - CMD: shift `spi_di` MSB-first on 8 rises. On the 8th rise, pulse `cmd_valid` and set `cmd_out`.
    - 0x05: go to STATUS.
    - 0x03: go to ADDR.
    - 0x9F (with the macro): go to ID.
    - Any other opcode: go to IGNORE.
  - STATUS: capture `status_in` on the 8th command rise. Shift it out MSB-first on falls. Recapture at each byte boundary and repeat until CS high.
  - ADDR: shift 24 bits MSB-first. On the 24th rise, load the address register, assert `mem_rd`, and go to DATA.
  - DATA: the byte arrives 1 clk after `mem_rd` and is loaded into the shift register. It is output MSB-first, one bit per fall.
    - On the rise that samples bit 0 of the current byte, increment the address and issue the next `mem_rd`.
    - The address wraps from 24'hFFFFFF to 24'h000000.
    - The stream is unbounded until CS high.
  - ID: shift out `JEDEC_ID[23:0]` MSB-first, then 1s until CS high.
  - IGNORE: `spi_do`=1, inputs ignored until CS high.
- Output bit rule: the first response bit is driven on the fall that follows the last command/address rise. The master samples it on the next rise.
- Reset: all state returns to IDLE. If `spi_cs` is low when `rst` deasserts, the block stays disarmed (IGNORE) until CS is seen high. A partial frame is never decoded.

## Timing
- Reset values:
  - `spi_do`=1
  - `mem_addr`=0
  - `mem_rd`=0
  - `cmd_out`=0
  - `cmd_valid`=0
  - `busy`=0
- Input latency is 2 clk (synchroniser) plus 1 clk (edge register). A change on `spi_do` appears ≤4 clk after the physical `spi_clk` fall.
- Constraint on the master: `spi_clk` high and low phases are each ≥4 clk. CS setup to the first rise is ≥4 clk, and CS high time is ≥4 clk. Behaviour is undefined otherwise.
- `mem_rd` precedes the use of `mem_data` by ≥1 SPI half-period. No back-pressure exists on the memory port.
- `cmd_valid` fires in the clk after the 8th rise is detected. It is also generated for unknown opcodes.
- CS rising during the same clk as a spi_clk edge: CS wins and the edge is discarded.

## Configuration
- `SPI_FLASH_RESP_JEDEC_EN` defined: opcode 0x9F enters ID and returns `JEDEC_ID`.
- `SPI_FLASH_RESP_JEDEC_EN` undefined: 0x9F is treated as unknown and enters IGNORE, with `spi_do` held at 1. The ID state and its logic are not compiled.

## Test plan
- Status read, with `status_in`=8'hA5 and master sending 0x05 then 16 clocks: master reads A5, A5; `cmd_valid` pulses once with `cmd_out`=05.
- Read at address 0x000010, memory model returning addr[7:0]^8'h5A, 3 bytes clocked: bytes 4A,4B,48; `mem_rd` seen at addresses 10,11,12 (plus at most one prefetch of 13).
- Wrap: 0x03 at address 0xFFFFFF, 2 bytes: `mem_addr` sequence FFFFFF then 000000.
- Abort: CS raised after 12 address bits: state returns to IDLE, `spi_do`=1, no `mem_rd`. The next 0x05 frame decodes correctly.
- Unknown opcode 0xAB then 8 clocks: `spi_do` stays 1 throughout, `cmd_out`=AB. Reset asserted with CS low, then deasserted mid-frame: no decode until CS goes high.
- With the macro defined, 0x9F then 24 clocks: master reads EF,40,16. Without the macro, the master reads FF,FF,FF.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI flash slave emulator: oversampled mode-0 link serving Read Status (0x05) and Read Data (0x03).
// Define SPI_FLASH_RESP_JEDEC_EN to add JEDEC ID (0x9F) responses.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_di,
    output logic        spi_do,
    input  logic [7:0]  status_in,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  cmd_out,
    output logic        cmd_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_STATUS = 3'd2,
        S_ADDR   = 3'd3,
        S_DATA   = 3'd4,
        S_IGNORE = 3'd5
`ifdef SPI_FLASH_RESP_JEDEC_EN
        , S_ID   = 3'd6
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sclk_p0, r_sclk_p1, r_sclk_p2;
    logic        r_cs_p0, r_cs_p1, r_cs_p2;
    logic        r_di_p0, r_di_p1;
    logic [4:0]  r_bitcnt;
    logic [22:0] r_shin;
    logic [7:0]  r_shout;
    logic [23:0] r_addr;
    logic        r_mem_rd, r_rd_p1;
    logic [7:0]  r_cmd_out;
    logic        r_cmd_valid;
    logic        r_spi_do;
    logic        w_busy, w_resp;
    logic        w_cs_hi, w_cs_fall, w_rise, w_fall, w_di, w_byte_end;
    logic [7:0]  w_opcode;
`ifdef SPI_FLASH_RESP_JEDEC_EN
    logic [1:0]  r_idx;

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'hFF;
        endcase
    endfunction
`endif

    // Stage p0/p1: two-flop synchronisers on the asynchronous SPI pins
    always_ff @(posedge clk) begin
        r_sclk_p0 <= spi_clk;
        r_sclk_p1 <= r_sclk_p0;
        r_cs_p0   <= spi_cs;
        r_cs_p1   <= r_cs_p0;
        r_di_p0   <= spi_di;
        r_di_p1   <= r_di_p0;
    end

    // Stage p2: edge registers; CS held "low" in reset so a frame already in progress is never armed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_p2 <= 1'b0;
            r_cs_p2   <= 1'b0;
        end else begin
            r_sclk_p2 <= r_sclk_p1;
            r_cs_p2   <= r_cs_p1;
        end
    end

    assign w_cs_hi    = r_cs_p1;
    assign w_cs_fall  = ~r_cs_p1 & r_cs_p2;
    assign w_rise     = r_sclk_p1 & ~r_sclk_p2;
    assign w_fall     = ~r_sclk_p1 & r_sclk_p2;
    assign w_di       = r_di_p1;
    assign w_byte_end = w_rise && (r_bitcnt == 5'd7);
    assign w_opcode   = {r_shin[6:0], w_di};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_hi) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
                S_CMD: begin
                    if (w_byte_end) begin
                        case (w_opcode)
                            8'h05:   w_state_nxt = S_STATUS;
                            8'h03:   w_state_nxt = S_ADDR;
`ifdef SPI_FLASH_RESP_JEDEC_EN
                            8'h9F:   w_state_nxt = S_ID;
`endif
                            default: w_state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: if (w_rise && (r_bitcnt == 5'd23)) w_state_nxt = S_DATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_resp = 1'b0;
        case (r_state)
            S_STATUS, S_DATA: w_resp = 1'b1;
`ifdef SPI_FLASH_RESP_JEDEC_EN
            S_ID:             w_resp = 1'b1;
`endif
            default:          w_resp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spi_do    <= 1'b1;
            r_addr      <= 24'd0;
            r_mem_rd    <= 1'b0;
            r_rd_p1     <= 1'b0;
            r_cmd_out   <= 8'd0;
            r_cmd_valid <= 1'b0;
            r_bitcnt    <= 5'd0;
`ifdef SPI_FLASH_RESP_JEDEC_EN
            r_idx       <= 2'd0;
`endif
        end else begin
            r_mem_rd    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_rd_p1     <= r_mem_rd;
            if (w_cs_hi) begin
                r_spi_do <= 1'b1;
                r_bitcnt <= 5'd0;
            end else begin
                case (r_state)
                    S_CMD, S_ADDR: begin
                        if (w_rise) begin
                            r_shin   <= {r_shin[21:0], w_di};
                            r_bitcnt <= r_bitcnt + 5'd1;
                            if (r_state == S_CMD && r_bitcnt == 5'd7) begin
                                r_bitcnt    <= 5'd0;
                                r_cmd_out   <= w_opcode;
                                r_cmd_valid <= 1'b1;
                                r_shout     <= status_in;
`ifdef SPI_FLASH_RESP_JEDEC_EN
                                if (w_opcode == 8'h9F) begin
                                    r_shout <= JEDEC_ID[23:16];
                                    r_idx   <= 2'd1;
                                end
`endif
                            end
                            if (r_state == S_ADDR && r_bitcnt == 5'd23) begin
                                r_bitcnt <= 5'd0;
                                r_addr   <= {r_shin, w_di};
                                r_mem_rd <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (w_resp) begin
                            if (w_fall) begin
                                r_spi_do <= r_shout[7];
                                r_shout  <= {r_shout[6:0], 1'b1};
                            end
                            if (w_rise) begin
                                r_bitcnt <= (r_bitcnt == 5'd7) ? 5'd0 : r_bitcnt + 5'd1;
                                // Byte boundary: the master has just sampled bit 0
                                if (r_bitcnt == 5'd7) begin
                                    if (r_state == S_STATUS) r_shout <= status_in;
                                    if (r_state == S_DATA) begin
                                        r_addr   <= r_addr + 24'd1;
                                        r_mem_rd <= 1'b1;
                                    end
`ifdef SPI_FLASH_RESP_JEDEC_EN
                                    if (r_state == S_ID) begin
                                        r_shout <= id_byte(r_idx);
                                        if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                                    end
`endif
                                end
                            end
                        end else begin
                            r_bitcnt <= 5'd0;
                        end
                    end
                endcase
                if (r_rd_p1) r_shout <= mem_data;
            end
        end
    end

    assign spi_do    = r_spi_do;
    assign mem_addr  = r_addr;
    assign mem_rd    = r_mem_rd;
    assign cmd_out   = r_cmd_out;
    assign cmd_valid = r_cmd_valid;
    assign busy      = w_busy;

endmodule
